// File: rtl/theta_pkg.sv
// ---------------------------------------------------------------------------
// theta_pkg
// Shared definitions for the multi-channel angle accumulator.
//   state_t    : control FSM states (IDLE, SOMA, NORMALIZA, GRAVA, DONE)
//   MODE_WRAP  : mode value selecting modular wrap
//   MODE_SAT   : mode value selecting saturation into [0, MOD-1]
//   normAngle  : normalisation rule applied to a raw signed sum
// ---------------------------------------------------------------------------
package theta_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SOMA      = 3'd1,
    S_NORMALIZA = 3'd2,
    S_GRAVA     = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Brings a raw sum back into [0, modulus-1]. The step is never wider than
  // the modulus, so a single add or subtract of the modulus is enough to wrap.
  function automatic int normAngle(input int sum, input int modulus, input logic mode);
    int res;
    res = sum;
    if (sum >= modulus) begin
      res = (mode == MODE_SAT) ? (modulus - 1) : (sum - modulus);
    end else if (sum < 0) begin
      res = (mode == MODE_SAT) ? 0 : (sum + modulus);
    end
    return res;
  endfunction

endpackage

// File: rtl/theta_accumulator_multi_uc.sv
// ---------------------------------------------------------------------------
// theta_accumulator_multi_uc
// Control FSM of the angle accumulator. Walks IDLE -> SOMA -> NORMALIZA ->
// GRAVA -> DONE -> IDLE for every accepted request.
// Ports:
//   clk, reset  : clock and synchronous active-high reset
//   start       : request strobe, only honoured in IDLE
//   clear       : zero-all request, only honoured in IDLE, beats start
//   soma        : high in SOMA (datapath computes the raw sum)
//   normaliza   : high in NORMALIZA (datapath normalises the sum)
//   grava       : high in GRAVA (datapath writes the channel back)
//   done        : one-cycle pulse in DONE
//   busy        : high in every state other than IDLE
// ---------------------------------------------------------------------------
module theta_accumulator_multi_uc
  import theta_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic clear,
  output logic soma,
  output logic normaliza,
  output logic grava,
  output logic done,
  output logic busy
);

  state_t state_q;
  state_t state_d;

  // State register. Reset returns to IDLE from anywhere, which also abandons
  // whatever request was in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and output decode. Outputs depend only on the state register,
  // so nothing from the inputs reaches an output in the same cycle. In IDLE a
  // clear keeps us idle even when start is also high.
  always_comb begin
    state_d   = state_q;
    soma      = 1'b0;
    normaliza = 1'b0;
    grava     = 1'b0;
    done      = 1'b0;
    busy      = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (!clear && start) begin
          state_d = S_SOMA;
        end
      end
      S_SOMA: begin
        soma    = 1'b1;
        state_d = S_NORMALIZA;
      end
      S_NORMALIZA: begin
        normaliza = 1'b1;
        state_d   = S_GRAVA;
      end
      S_GRAVA: begin
        grava   = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/theta_accumulator_multi.sv
// ---------------------------------------------------------------------------
// theta_accumulator_multi
// N_CH independent angle registers. Each accepted request adds a signed step
// to one channel, normalises the result into [0, MOD-1] by wrap or
// saturation, and writes it back. Used as the shared heading/rotation engine.
// Ports:
//   clk, reset  : clock and synchronous active-high reset
//   start       : request strobe (IDLE only); latches ch_sel, delta, mode
//   clear       : zero every channel (IDLE only, beats start)
//   ch_sel      : target channel
//   delta       : signed two's-complement step
//   mode        : 0 = wrap, 1 = saturate
//   busy        : request in progress
//   soma        : sum phase
//   normaliza   : normalisation phase
//   done        : one-cycle completion pulse
//   err         : pulses with done when the latched channel does not exist
//   theta_all   : all channels packed, channel i at [i*WIDTH +: WIDTH]
// ---------------------------------------------------------------------------
module theta_accumulator_multi
  import theta_pkg::*;
#(
  parameter int WIDTH  = 10,
  parameter int MOD    = 360,
  parameter int N_CH   = 4,
  parameter int STEP_W = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      clear,
  input  logic [$clog2(N_CH)-1:0]   ch_sel,
  input  logic [STEP_W-1:0]         delta,
  input  logic                      mode,
  output logic                      busy,
  output logic                      soma,
  output logic                      normaliza,
  output logic                      done,
  output logic                      err,
  output logic [N_CH*WIDTH-1:0]     theta_all
);

  localparam int CH_W  = $clog2(N_CH);
  localparam int SUM_W = WIDTH + 2;

  logic                    grava;
  logic                    accept;
  logic                    clearHit;
  logic                    chHit;

  logic [WIDTH-1:0]        theta_q [N_CH];
  logic [CH_W-1:0]         chSel_q;
  logic [STEP_W-1:0]       delta_q;
  logic                    mode_q;
  logic                    chBad_q;
  logic signed [SUM_W-1:0] sum_q;
  logic signed [SUM_W-1:0] sum_d;
  logic [WIDTH-1:0]        norm_q;
  logic [WIDTH-1:0]        norm_d;
  logic [WIDTH-1:0]        thetaSel;

  theta_accumulator_multi_uc u_uc (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .clear     (clear),
    .soma      (soma),
    .normaliza (normaliza),
    .grava     (grava),
    .done      (done),
    .busy      (busy)
  );

  // The FSM only listens to start/clear in IDLE, so the datapath gates its
  // own latch and clear the same way to stay in step with it.
  assign clearHit = !busy && clear;
  assign accept   = !busy && start && !clear;

  // A channel index is valid only if it matches one of the real channels.
  // With a non power-of-two N_CH the top codes of ch_sel name nothing.
  always_comb begin
    chHit = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (ch_sel == CH_W'(i)) begin
        chHit = 1'b1;
      end
    end
  end

  // Read mux for the latched channel. Going through a compare loop rather
  // than a direct index keeps an invalid channel from reading off the end of
  // the array; it simply reads zero, and the write-back is suppressed anyway.
  always_comb begin
    thetaSel = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (chSel_q == CH_W'(i)) begin
        thetaSel = theta_q[i];
      end
    end
  end

  // Raw sum in WIDTH+2 signed bits: the angle is zero-extended, the step is
  // sign-extended, so the result covers both overflow above MOD and underflow
  // below zero without losing the sign.
  assign sum_d = $signed({2'b00, thetaSel})
               + $signed({{(SUM_W-STEP_W){delta_q[STEP_W-1]}}, delta_q});

  // Normalised value always lands in [0, MOD-1], so WIDTH bits hold it.
  assign norm_d = WIDTH'(normAngle(int'(sum_q), MOD, mode_q));

  // Request latches and the two pipeline registers of the datapath. Reset
  // clears everything so an aborted request leaves nothing behind.
  always_ff @(posedge clk) begin
    if (reset) begin
      chSel_q <= '0;
      delta_q <= '0;
      mode_q  <= MODE_WRAP;
      chBad_q <= 1'b0;
      sum_q   <= '0;
      norm_q  <= '0;
    end else begin
      if (accept) begin
        chSel_q <= ch_sel;
        delta_q <= delta;
        mode_q  <= mode;
        chBad_q <= !chHit;
      end
      if (soma) begin
        sum_q <= sum_d;
      end
      if (normaliza) begin
        norm_q <= norm_d;
      end
    end
  end

  // Channel register array. Only the latched channel is written, and only
  // when it exists; every other channel holds its value through a request.
  always_ff @(posedge clk) begin
    if (reset || clearHit) begin
      for (int i = 0; i < N_CH; i++) begin
        theta_q[i] <= '0;
      end
    end else if (grava && !chBad_q) begin
      for (int i = 0; i < N_CH; i++) begin
        if (chSel_q == CH_W'(i)) begin
          theta_q[i] <= norm_q;
        end
      end
    end
  end

  // Flatten the channel array onto the output bus.
  always_comb begin
    theta_all = '0;
    for (int i = 0; i < N_CH; i++) begin
      theta_all[i*WIDTH +: WIDTH] = theta_q[i];
    end
  end

  // The error flag rides on the done pulse and the latched validity bit.
  assign err = done && chBad_q;

endmodule
